// File: rtl/ir_nec_rx.sv
// NEC infrared remote receiver: synchronise and deglitch the receiver output, time the
// low/high phases in microsecond ticks, decode 32-bit frames and repeat codes.
module ir_nec_rx #(
  parameter int CLK_FREQ_HZ       = 50_000_000,
  parameter int FILTER_LEN        = 8,
  parameter int EXT_ADDR          = 0,
  parameter int REPEAT_TIMEOUT_US = 120000,
  // Divides every pulse-window limit; 1 gives real NEC timing, larger values compress it.
  parameter int TIME_DIV          = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        remote_in,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        frame_valid,
  output logic        repeat_pulse,
  output logic [7:0]  repeat_cnt,
  output logic        held,
  output logic        frame_err,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [7:0]  FILT_MAX   = 8'(FILTER_LEN - 1);
  localparam logic [16:0] RPT_MAX    = 17'(REPEAT_TIMEOUT_US);
  localparam logic [15:0] LEAD_MIN   = 16'(8000 / TIME_DIV);
  localparam logic [15:0] LEAD_MAX   = 16'(10000 / TIME_DIV);
  localparam logic [15:0] SPACE_MIN  = 16'(4000 / TIME_DIV);
  localparam logic [15:0] SPACE_MAX  = 16'(5000 / TIME_DIV);
  localparam logic [15:0] RSPACE_MIN = 16'(2000 / TIME_DIV);
  localparam logic [15:0] RSPACE_MAX = 16'(2500 / TIME_DIV);
  localparam logic [15:0] BIT_MIN    = 16'(400 / TIME_DIV);
  localparam logic [15:0] BIT_MAX    = 16'(700 / TIME_DIV);
  localparam logic [15:0] ONE_MIN    = 16'(1400 / TIME_DIV);
  localparam logic [15:0] ONE_MAX    = 16'(1900 / TIME_DIV);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LEAD_LOW  = 3'd1,
    LEAD_HIGH = 3'd2,
    BIT_LOW   = 3'd3,
    BIT_HIGH  = 3'd4,
    REP_LOW   = 3'd5,
    ERR_WAIT  = 3'd6
  } state_t;

  state_t        state_q;
  logic [1:0]    sync_q;
  logic          filt_q;
  logic          filt_prev_q;
  logic [7:0]    filt_cnt_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   dur_q;
  logic [5:0]    bit_idx_q;
  logic [31:0]   shift_q;
  logic [15:0]   addr_q;
  logic [7:0]    cmd_q;
  logic          frame_valid_q;
  logic          repeat_pulse_q;
  logic          frame_err_q;
  logic [7:0]    repeat_cnt_q;
  logic          held_q;
  logic [16:0]   rpt_tmr_q;

  logic        tick;
  logic        f_edge;
  logic        rise;
  logic        fall;
  logic        frame_ok;
  logic [15:0] addr_d;
  logic [7:0]  repeat_cnt_d;

  function automatic logic in_win(input logic [15:0] d, input logic [15:0] lo,
                                  input logic [15:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  assign tick   = (presc_q == PRESC_MAX);
  assign f_edge = filt_q ^ filt_prev_q;
  assign rise   = f_edge & filt_q;
  assign fall   = f_edge & ~filt_q;

  // shift_q holds the frame LSB first: byte0 in [7:0] up to byte3 in [31:24].
  assign frame_ok = (shift_q[31:24] == ~shift_q[23:16]) &&
                    ((EXT_ADDR != 0) || (shift_q[15:8] == ~shift_q[7:0]));
  assign addr_d       = (EXT_ADDR != 0) ? shift_q[15:0] : {8'h00, shift_q[7:0]};
  assign repeat_cnt_d = (repeat_cnt_q == 8'hFF) ? 8'hFF : repeat_cnt_q + 8'd1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q      <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
      presc_q     <= '0;
      dur_q       <= '0;
    end else begin
      sync_q      <= {sync_q[0], remote_in};
      filt_prev_q <= filt_q;
      if (sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_MAX) begin
        filt_q     <= sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 8'd1;
      end
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (f_edge) dur_q <= '0;
      else if (tick && dur_q != 16'hFFFF) dur_q <= dur_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      addr_q         <= '0;
      cmd_q          <= '0;
      frame_valid_q  <= 1'b0;
      repeat_pulse_q <= 1'b0;
      frame_err_q    <= 1'b0;
      repeat_cnt_q   <= '0;
      held_q         <= 1'b0;
      rpt_tmr_q      <= '0;
    end else begin
      frame_valid_q  <= 1'b0;
      repeat_pulse_q <= 1'b0;
      frame_err_q    <= 1'b0;
      // Window expiry first; a frame or repeat accepted below overrides it.
      if (held_q) begin
        if (rpt_tmr_q == RPT_MAX) begin
          held_q       <= 1'b0;
          repeat_cnt_q <= '0;
          rpt_tmr_q    <= '0;
        end else if (tick) begin
          rpt_tmr_q <= rpt_tmr_q + 17'd1;
        end
      end
      case (state_q)
        IDLE: if (fall) state_q <= LEAD_LOW;
        LEAD_LOW: begin
          if (rise) begin
            if (in_win(dur_q, LEAD_MIN, LEAD_MAX)) begin
              state_q <= LEAD_HIGH;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ERR_WAIT;
            end
          end else if (dur_q > LEAD_MAX) begin
            frame_err_q <= 1'b1;
            state_q     <= ERR_WAIT;
          end
        end
        LEAD_HIGH: begin
          if (fall) begin
            if (in_win(dur_q, SPACE_MIN, SPACE_MAX)) begin
              bit_idx_q <= '0;
              state_q   <= BIT_LOW;
            end else if (in_win(dur_q, RSPACE_MIN, RSPACE_MAX)) begin
              state_q <= REP_LOW;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ERR_WAIT;
            end
          end else if (dur_q > SPACE_MAX) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        BIT_LOW: begin
          if (rise) begin
            if (!in_win(dur_q, BIT_MIN, BIT_MAX)) begin
              frame_err_q <= 1'b1;
              state_q     <= IDLE;
            end else if (bit_idx_q == 6'd32) begin
              if (frame_ok) begin
                addr_q        <= addr_d;
                cmd_q         <= shift_q[23:16];
                frame_valid_q <= 1'b1;
                repeat_cnt_q  <= '0;
                held_q        <= 1'b1;
                rpt_tmr_q     <= '0;
              end else begin
                frame_err_q <= 1'b1;
              end
              state_q <= IDLE;
            end else begin
              state_q <= BIT_HIGH;
            end
          end else if (dur_q > BIT_MAX) begin
            frame_err_q <= 1'b1;
            state_q     <= ERR_WAIT;
          end
        end
        BIT_HIGH: begin
          if (fall) begin
            if (in_win(dur_q, BIT_MIN, BIT_MAX) || in_win(dur_q, ONE_MIN, ONE_MAX)) begin
              shift_q   <= {in_win(dur_q, ONE_MIN, ONE_MAX), shift_q[31:1]};
              bit_idx_q <= bit_idx_q + 6'd1;
              state_q   <= BIT_LOW;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ERR_WAIT;
            end
          end else if (dur_q > ONE_MAX) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        REP_LOW: begin
          if (rise) begin
            if (in_win(dur_q, BIT_MIN, BIT_MAX)) begin
              // A repeat with no open window is ignored without complaint.
              if (held_q) begin
                repeat_pulse_q <= 1'b1;
                repeat_cnt_q   <= repeat_cnt_d;
                held_q         <= 1'b1;
                rpt_tmr_q      <= '0;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= IDLE;
          end else if (dur_q > BIT_MAX) begin
            frame_err_q <= 1'b1;
            state_q     <= ERR_WAIT;
          end
        end
        ERR_WAIT: if (filt_q) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign addr         = addr_q;
  assign cmd          = cmd_q;
  assign frame_valid  = frame_valid_q;
  assign repeat_pulse = repeat_pulse_q;
  assign repeat_cnt   = repeat_cnt_q;
  assign held         = held_q;
  assign frame_err    = frame_err_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ir_nec_rx.sv
// Directed bench for ir_nec_rx with compressed timing (1 MHz clock, windows divided by 20);
// decoder pulses are scored against an expected-event queue filled as stimulus is driven.
`timescale 1ns/1ps
module tb_ir_nec_rx;

  localparam int W         = 26;   // {kind[1:0], addr[15:0], cmd[7:0]}
  localparam int FLEN      = 8;
  localparam int TDIV      = 20;
  localparam int T_LEAD    = 9000 / TDIV;
  localparam int T_SPACE   = 4500 / TDIV;
  localparam int T_RSPACE  = 2250 / TDIV;
  localparam int T_MARK    = 560 / TDIV;
  localparam int T_ONE     = 1690 / TDIV;
  localparam int T_PERIOD  = 108000 / TDIV;
  localparam int T_RTO     = 120000 / TDIV;
  localparam int PULSE_LAT = 2 + FLEN + 1;

  localparam logic [1:0] EV_VALID  = 2'd1;
  localparam logic [1:0] EV_REPEAT = 2'd2;
  localparam logic [1:0] EV_ERR    = 2'd3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rin0 = 1'b1;
  logic        rin1 = 1'b1;
  logic [15:0] addr0, addr1;
  logic [7:0]  cmd0, cmd1, rcnt0, rcnt1;
  logic        fv0, fv1, rp0, rp1, held0, held1, fe0, fe1, busy0, busy1;
  logic [2:0]  st0, st1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pulse_cyc = 0;
  int last_rise_cyc = 0;
  int fv1_cnt = 0;
  int fe1_cnt = 0;
  int t0 = 0;
  logic [W-1:0] exp_q[$];

  ir_nec_rx #(.CLK_FREQ_HZ(1_000_000), .FILTER_LEN(FLEN), .EXT_ADDR(0),
              .REPEAT_TIMEOUT_US(T_RTO), .TIME_DIV(TDIV)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .remote_in(rin0), .addr(addr0), .cmd(cmd0),
    .frame_valid(fv0), .repeat_pulse(rp0), .repeat_cnt(rcnt0), .held(held0),
    .frame_err(fe0), .busy(busy0), .dbg_state(st0));

  ir_nec_rx #(.CLK_FREQ_HZ(1_000_000), .FILTER_LEN(FLEN), .EXT_ADDR(1),
              .REPEAT_TIMEOUT_US(T_RTO), .TIME_DIV(TDIV)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .remote_in(rin1), .addr(addr1), .cmd(cmd1),
    .frame_valid(fv1), .repeat_pulse(rp1), .repeat_cnt(rcnt1), .held(held1),
    .frame_err(fe1), .busy(busy1), .dbg_state(st1));

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for dut0: every pulse pops one expected event.
  always @(negedge sys_clk) begin : mon0
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    if (!sys_rst && (fv0 || rp0 || fe0)) begin
      last_pulse_cyc = cyc;
      check("pulse_exclusive", {31'd0, $onehot0({fv0, rp0, fe0})}, 32'd1);
      obs = {fv0 ? EV_VALID : (rp0 ? EV_REPEAT : EV_ERR), addr0, cmd0};
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {6'd0, obs}, 32'd0);
      end else begin
        exp_v = exp_q.pop_front();
        check("event", {6'd0, obs}, {6'd0, exp_v});
      end
    end
  end

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (fv1) fv1_cnt++;
      if (fe1) fe1_cnt++;
    end
  end

  function automatic logic [31:0] nec_word(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  task automatic drive(input logic lvl, input int n, input bit sel);
    if (sel) rin1 = lvl;
    else rin0 = lvl;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge sys_clk);
  endtask

  // abort_after >= 0 stops after that bit's space, leaving the line high.
  task automatic send_frame(input logic [31:0] bits, input bit sel, input bit glitch,
                            input int abort_after);
    int sp;
    drive(1'b0, T_LEAD, sel);
    drive(1'b1, T_SPACE, sel);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, T_MARK, sel);
      sp = bits[i] ? T_ONE : T_MARK;
      if (glitch && bits[i]) begin
        drive(1'b1, 40, sel);
        drive(1'b0, 3, sel);
        drive(1'b1, sp - 43, sel);
      end else begin
        drive(1'b1, sp, sel);
      end
      if (i == abort_after) return;
    end
    drive(1'b0, T_MARK, sel);
    last_rise_cyc = cyc;
    if (sel) rin1 = 1'b1;
    else rin0 = 1'b1;
  endtask

  task automatic send_repeat(input bit sel);
    drive(1'b0, T_LEAD, sel);
    drive(1'b1, T_RSPACE, sel);
    drive(1'b0, T_MARK, sel);
    last_rise_cyc = cyc;
    if (sel) rin1 = 1'b1;
    else rin0 = 1'b1;
  endtask

  initial begin
    sys_rst = 1'b1;
    repeat (6) @(negedge sys_clk);
    check("rst_addr", {16'd0, addr0}, 32'h0);
    check("rst_cmd", {24'd0, cmd0}, 32'h0);
    check("rst_held", {31'd0, held0}, 32'h0);
    check("rst_rcnt", {24'd0, rcnt0}, 32'h0);
    check("rst_busy", {31'd0, busy0}, 32'h0);
    check("rst_pulses", {29'd0, fv0, rp0, fe0}, 32'h0);
    sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);

    // Good frame addr 0x00 cmd 0x45
    t0 = cyc;
    exp_q.push_back({EV_VALID, 16'h0000, 8'h45});
    send_frame(nec_word(8'h00, 8'h45), 1'b0, 1'b0, -1);
    repeat (20) @(negedge sys_clk);
    check("valid_latency", last_pulse_cyc - last_rise_cyc, PULSE_LAT);
    check("f1_addr", {16'd0, addr0}, 32'h0000);
    check("f1_cmd", {24'd0, cmd0}, 32'h45);
    check("f1_held", {31'd0, held0}, 32'h1);
    check("f1_rcnt", {24'd0, rcnt0}, 32'h0);
    check("f1_busy", {31'd0, busy0}, 32'h0);

    // Three repeats at frame period spacing
    for (int r = 1; r <= 3; r++) begin
      wait_until(t0 + r * T_PERIOD);
      exp_q.push_back({EV_REPEAT, 16'h0000, 8'h45});
      send_repeat(1'b0);
      repeat (20) @(negedge sys_clk);
      check("rpt_cnt", {24'd0, rcnt0}, r);
    end
    check("rpt_latency", last_pulse_cyc - last_rise_cyc, PULSE_LAT);
    wait_until(last_rise_cyc + T_RTO - 100);
    check("held_before_timeout", {31'd0, held0}, 32'h1);
    wait_until(last_rise_cyc + PULSE_LAT + T_RTO + 20);
    check("held_after_timeout", {31'd0, held0}, 32'h0);
    check("rcnt_after_timeout", {24'd0, rcnt0}, 32'h0);

    // Corrupt inverse command byte
    exp_q.push_back({EV_ERR, 16'h0000, 8'h45});
    send_frame({8'hBB, 8'h45, 8'hFF, 8'h00}, 1'b0, 1'b0, -1);
    repeat (20) @(negedge sys_clk);
    check("bad_addr_kept", {16'd0, addr0}, 32'h0000);
    check("bad_cmd_kept", {24'd0, cmd0}, 32'h45);

    // Repeat with the window closed: nothing expected
    send_repeat(1'b0);
    repeat (20) @(negedge sys_clk);
    check("orphan_rcnt", {24'd0, rcnt0}, 32'h0);
    check("orphan_held", {31'd0, held0}, 32'h0);

    // Short low glitches inside each one-bit space
    exp_q.push_back({EV_VALID, 16'h0012, 8'h34});
    send_frame(nec_word(8'h12, 8'h34), 1'b0, 1'b1, -1);
    repeat (20) @(negedge sys_clk);
    check("glitch_addr", {16'd0, addr0}, 32'h0012);
    check("glitch_cmd", {24'd0, cmd0}, 32'h34);
    check("glitch_held", {31'd0, held0}, 32'h1);

    // Leader low far too short
    exp_q.push_back({EV_ERR, 16'h0012, 8'h34});
    drive(1'b0, 300, 1'b0);
    rin0 = 1'b1;
    repeat (40) @(negedge sys_clk);
    check("short_lead_idle", {31'd0, busy0}, 32'h0);

    // Reset in the middle of a frame, then a clean frame
    send_frame(nec_word(8'h55, 8'h0C), 1'b0, 1'b0, 12);
    check("mid_frame_busy", {31'd0, busy0}, 32'h1);
    sys_rst = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("mid_rst_busy", {31'd0, busy0}, 32'h0);
    check("mid_rst_held", {31'd0, held0}, 32'h0);
    check("mid_rst_cmd", {24'd0, cmd0}, 32'h0);
    sys_rst = 1'b0;
    repeat (50) @(negedge sys_clk);
    exp_q.push_back({EV_VALID, 16'h0055, 8'h0C});
    send_frame(nec_word(8'h55, 8'h0C), 1'b0, 1'b0, -1);
    repeat (20) @(negedge sys_clk);
    check("post_rst_cmd", {24'd0, cmd0}, 32'h0C);
    check("post_rst_addr", {16'd0, addr0}, 32'h0055);

    // Extended address on the second instance
    send_frame({8'hE9, 8'h16, 8'hEF, 8'h10}, 1'b1, 1'b0, -1);
    repeat (20) @(negedge sys_clk);
    check("ext_addr", {16'd0, addr1}, 32'hEF10);
    check("ext_cmd", {24'd0, cmd1}, 32'h16);
    check("ext_valid_cnt", fv1_cnt, 1);
    check("ext_err_cnt", fe1_cnt, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
